// File: rtl/odu_chk_pkg.sv
// odu_chk_pkg: shared state encoding, byte width and saturating-increment
// helper for the multi-channel ODU sequence checker.
package odu_chk_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } chk_state_e;

  localparam int BYTE_W = 8;
  localparam int SAT_W  = 64;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    logic [SAT_W-1:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/odu_chk_word_cmp.sv
// odu_chk_word_cmp: combinational byte-window comparator. Byte 0 sits at the
// MSB end; when rs is set the leading OH_BYTES overhead bytes are skipped and
// the incrementing pattern restarts at the first payload byte.
module odu_chk_word_cmp
  import odu_chk_pkg::*;
#(
  parameter int DATA_W   = 384,
  parameter int OH_BYTES = 2
) (
  input  logic [DATA_W-1:0] data,
  input  logic [7:0]        last_byte,
  input  logic              rs,
  output logic              match
);

  localparam int         NB   = DATA_W / BYTE_W;
  localparam logic [7:0] OH_B = 8'(OH_BYTES);

  logic [7:0]    base_s;
  logic [NB-1:0] byte_ok_s;

  // Expected value of byte k is base_s + k, with base shifted back over overhead.
  always_comb begin
    if (rs) begin
      base_s = last_byte - OH_B + 8'd1;
    end else begin
      base_s = last_byte + 8'd1;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_byte
    localparam logic [7:0] K_B = 8'(k);
    logic [7:0] byte_s;
    assign byte_s = data[DATA_W-1-BYTE_W*k -: BYTE_W];
    if (k < OH_BYTES) begin : g_oh
      assign byte_ok_s[k] = rs | (byte_s == base_s + K_B);
    end else begin : g_pl
      assign byte_ok_s[k] = (byte_s == base_s + K_B);
    end
  end

  assign match = &byte_ok_s;

endmodule

// File: rtl/odu_seq_checker_mc.sv
// odu_seq_checker_mc: checks incrementing-byte payload and MFAS continuity for
// N_CH time-multiplexed channels, each with HUNT/SYNC/LOCK hysteresis, and
// keeps saturating per-channel statistics behind a clear-on-read port.
// Build option: define ODU_SEQ_CHK_WERR_EN to implement the bad-word counter;
// without it o_rd_werr reads 0.
module odu_seq_checker_mc
  import odu_chk_pkg::*;
#(
  parameter  int N_CH     = 8,
  parameter  int DATA_W   = 384,
  parameter  int OH_BYTES = 2,
  parameter  int LOCK_N   = 4,
  parameter  int LOSS_N   = 3,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_chid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_fs,
  input  logic              i_rs,
  input  logic [7:0]        i_mfas,
  input  logic              i_rd_req,
  input  logic [CH_W-1:0]   i_rd_chid,
  input  logic              i_rd_clr,
  output logic [N_CH-1:0]   o_lock,
  output logic              o_err_pulse,
  output logic [CH_W-1:0]   o_err_chid,
  output logic              o_rd_valid,
  output logic [CNT_W-1:0]  o_rd_frames,
  output logic [CNT_W-1:0]  o_rd_ferr,
  output logic [CNT_W-1:0]  o_rd_werr
);

  localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);
  localparam logic [3:0]       LOSS_N_C = 4'(LOSS_N);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  chk_state_e       state_r     [N_CH];
  logic [3:0]       run_r       [N_CH];
  logic [7:0]       last_byte_r [N_CH];
  logic [7:0]       last_mfas_r [N_CH];
  logic [CNT_W-1:0] frames_r    [N_CH];
  logic [CNT_W-1:0] ferr_r      [N_CH];
  logic [CNT_W-1:0] frames_nxt_s[N_CH];
  logic [CNT_W-1:0] ferr_nxt_s  [N_CH];

  chk_state_e      cur_state_s, nxt_state_s;
  logic [3:0]      cur_run_s, nxt_run_s;
  logic [7:0]      cur_last_byte_s, cur_last_mfas_s;
  logic            byte_match_s, mfas_ok_s, good_s, bad_s, frame_ev_s;
  logic [N_CH-1:0] lock_nxt_s;

  // Clear (optional) then saturating increment (optional) of one counter.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cur,
                                                input logic clr, input logic ev);
    logic [CNT_W-1:0] base;
    logic [SAT_W-1:0] inc;
    logic [CNT_W-1:0] res;
    if (clr) begin
      base = CNT_ZERO;
    end else begin
      base = cur;
    end
    inc = sat_inc(SAT_W'(base), SAT_W'(CNT_MAX));
    if (ev) begin
      res = inc[CNT_W-1:0];
    end else begin
      res = base;
    end
    return res;
  endfunction

  // The context is read straight from the registers and written back on the
  // word's own edge, so a back-to-back word on the same channel always sees
  // the freshly updated state without any stall.
  assign cur_state_s     = state_r[i_chid];
  assign cur_run_s       = run_r[i_chid];
  assign cur_last_byte_s = last_byte_r[i_chid];
  assign cur_last_mfas_s = last_mfas_r[i_chid];

  odu_chk_word_cmp #(
    .DATA_W   (DATA_W),
    .OH_BYTES (OH_BYTES)
  ) u_cmp (
    .data      (i_data),
    .last_byte (cur_last_byte_s),
    .rs        (i_rs),
    .match     (byte_match_s)
  );

  // MFAS holds within a frame and steps by one at each frame start.
  always_comb begin
    if (i_fs) begin
      mfas_ok_s = (i_mfas == cur_last_mfas_s + 8'd1);
    end else begin
      mfas_ok_s = (i_mfas == cur_last_mfas_s);
    end
  end

  assign good_s     = byte_match_s & mfas_ok_s;
  assign bad_s      = i_valid & (cur_state_s != HUNT) & ~good_s;
  assign frame_ev_s = i_valid & i_fs & i_rs;

  // Next-state and run counter for the channel addressed this cycle.
  always_comb begin
    nxt_state_s = cur_state_s;
    nxt_run_s   = cur_run_s;
    case (cur_state_s)
      HUNT: begin
        if (i_fs && i_rs) begin
          nxt_state_s = SYNC;
          nxt_run_s   = 4'd0;
        end else begin
          nxt_state_s = HUNT;
        end
      end
      SYNC: begin
        if (!good_s) begin
          nxt_state_s = HUNT;
          nxt_run_s   = 4'd0;
        end else if (cur_run_s + 4'd1 == LOCK_N_C) begin
          nxt_state_s = LOCK;
          nxt_run_s   = 4'd0;
        end else begin
          nxt_run_s   = cur_run_s + 4'd1;
        end
      end
      LOCK: begin
        if (good_s) begin
          nxt_run_s   = 4'd0;
        end else if (cur_run_s + 4'd1 == LOSS_N_C) begin
          nxt_state_s = HUNT;
          nxt_run_s   = 4'd0;
        end else begin
          nxt_run_s   = cur_run_s + 4'd1;
        end
      end
      default: begin
        nxt_state_s = HUNT;
        nxt_run_s   = 4'd0;
      end
    endcase
  end

  // Lock flags as they will stand once this cycle's update has landed.
  always_comb begin
    lock_nxt_s = {N_CH{1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      if (i_valid && (i_chid == CH_W'(c))) begin
        lock_nxt_s[c] = (nxt_state_s == LOCK);
      end else begin
        lock_nxt_s[c] = (state_r[c] == LOCK);
      end
    end
  end

  // Counter next values: a read-clear lands before a same-cycle increment.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      frames_nxt_s[c] = cnt_step(frames_r[c],
                                 i_rd_req & i_rd_clr & (i_rd_chid == CH_W'(c)),
                                 frame_ev_s & (i_chid == CH_W'(c)));
      ferr_nxt_s[c]   = cnt_step(ferr_r[c],
                                 i_rd_req & i_rd_clr & (i_rd_chid == CH_W'(c)),
                                 frame_ev_s & (i_chid == CH_W'(c)) & (cur_state_s != LOCK));
    end
  end

  // Per-channel context and frame statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        state_r[c]     <= HUNT;
        run_r[c]       <= 4'd0;
        last_byte_r[c] <= 8'd0;
        last_mfas_r[c] <= 8'd0;
        frames_r[c]    <= CNT_ZERO;
        ferr_r[c]      <= CNT_ZERO;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_valid && (i_chid == CH_W'(c))) begin
          state_r[c]     <= nxt_state_s;
          run_r[c]       <= nxt_run_s;
          last_byte_r[c] <= i_data[7:0];
          last_mfas_r[c] <= i_mfas;
        end
        frames_r[c] <= frames_nxt_s[c];
        ferr_r[c]   <= ferr_nxt_s[c];
      end
    end
  end

  // Registered lock flags, error pulse and frame-statistics read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lock      <= {N_CH{1'b0}};
      o_err_pulse <= 1'b0;
      o_err_chid  <= {CH_W{1'b0}};
      o_rd_valid  <= 1'b0;
      o_rd_frames <= CNT_ZERO;
      o_rd_ferr   <= CNT_ZERO;
    end else begin
      o_lock      <= lock_nxt_s;
      o_err_pulse <= bad_s;
      o_err_chid  <= bad_s ? i_chid : {CH_W{1'b0}};
      o_rd_valid  <= i_rd_req;
      o_rd_frames <= i_rd_req ? frames_r[i_rd_chid] : CNT_ZERO;
      o_rd_ferr   <= i_rd_req ? ferr_r[i_rd_chid] : CNT_ZERO;
    end
  end

`ifdef ODU_SEQ_CHK_WERR_EN
  logic [CNT_W-1:0] werr_r     [N_CH];
  logic [CNT_W-1:0] werr_nxt_s [N_CH];

  // Bad-word counter next values, same clear-then-increment ordering.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      werr_nxt_s[c] = cnt_step(werr_r[c],
                               i_rd_req & i_rd_clr & (i_rd_chid == CH_W'(c)),
                               bad_s & (i_chid == CH_W'(c)));
    end
  end

  // Bad-word counter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        werr_r[c] <= CNT_ZERO;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        werr_r[c] <= werr_nxt_s[c];
      end
    end
  end

  // Bad-word read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_werr <= CNT_ZERO;
    end else begin
      o_rd_werr <= i_rd_req ? werr_r[i_rd_chid] : CNT_ZERO;
    end
  end
`else
  // Bad-word counter not built: read data is constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_werr <= CNT_ZERO;
    end else begin
      o_rd_werr <= CNT_ZERO;
    end
  end
`endif

endmodule

// File: tb/tb_odu_seq_checker_mc.sv
// tb_odu_seq_checker_mc: table-driven lock/loss sequence, directed corner
// cases and randomized traffic, all checked against a behavioural model of
// the per-channel rules.
module tb_odu_seq_checker_mc;

  localparam int N_CH     = 8;
  localparam int CH_W     = 3;
  localparam int DATA_W   = 384;
  localparam int NB       = DATA_W / 8;
  localparam int OH_BYTES = 2;
  localparam int LOCK_N   = 4;
  localparam int LOSS_N   = 3;
  localparam int CNT_W    = 16;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int H = 0, S = 1, L = 2;

`ifdef ODU_SEQ_CHK_WERR_EN
  localparam bit WERR_EN = 1'b1;
`else
  localparam bit WERR_EN = 1'b0;
`endif

  logic              clk, rst;
  logic              i_valid, i_fs, i_rs, i_rd_req, i_rd_clr;
  logic [CH_W-1:0]   i_chid, i_rd_chid;
  logic [DATA_W-1:0] i_data;
  logic [7:0]        i_mfas;
  logic [N_CH-1:0]   o_lock;
  logic              o_err_pulse, o_rd_valid;
  logic [CH_W-1:0]   o_err_chid;
  logic [CNT_W-1:0]  o_rd_frames, o_rd_ferr, o_rd_werr;

  odu_seq_checker_mc dut (
    .clk (clk), .rst (rst), .i_valid (i_valid), .i_chid (i_chid), .i_data (i_data),
    .i_fs (i_fs), .i_rs (i_rs), .i_mfas (i_mfas), .i_rd_req (i_rd_req),
    .i_rd_chid (i_rd_chid), .i_rd_clr (i_rd_clr), .o_lock (o_lock),
    .o_err_pulse (o_err_pulse), .o_err_chid (o_err_chid), .o_rd_valid (o_rd_valid),
    .o_rd_frames (o_rd_frames), .o_rd_ferr (o_rd_ferr), .o_rd_werr (o_rd_werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: per-channel mode, run of consecutive good/bad words,
  // last byte / mfas seen and the three statistics.
  int         m_st [N_CH];
  int         m_cnt[N_CH];
  logic [7:0] m_lb [N_CH];
  logic [7:0] m_lm [N_CH];
  int         m_fr [N_CH];
  int         m_fe [N_CH];
  int         m_we [N_CH];

  typedef struct {
    int              ch;
    bit              fs;
    bit              rs;
    bit              bad;
    logic [N_CH-1:0] exp_lock;
    bit              exp_err;
  } vec_t;
  vec_t tbl[11];

  int                r_ch, r_rch;
  bit                r_v, r_fs, r_rs, r_rq, r_clr;
  logic [7:0]        r_m;
  logic [DATA_W-1:0] r_d;

  task automatic do_check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_st[c] = H; m_cnt[c] = 0; m_lb[c] = 8'd0; m_lm[c] = 8'd0;
      m_fr[c] = 0; m_fe[c] = 0; m_we[c] = 0;
    end
  endtask

  function automatic int sat1(input int x);
    return (x < CNT_MAX) ? x + 1 : x;
  endfunction

  function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] d, input int k);
    return d[DATA_W-1-8*k -: 8];
  endfunction

  // Payload must run last+1, last+2, ... from the first checked byte on.
  function automatic bit m_good(input int ch, input logic [DATA_W-1:0] d, input bit fs,
                                input bit rs, input logic [7:0] m);
    logic [7:0] want;
    want = m_lb[ch] + 8'd1;
    for (int k = (rs ? OH_BYTES : 0); k < NB; k++) begin
      if (byte_at(d, k) != want) return 1'b0;
      want = want + 8'd1;
    end
    if (fs) return (m == m_lm[ch] + 8'd1);
    return (m == m_lm[ch]);
  endfunction

  function automatic logic [DATA_W-1:0] mkword(input logic [7:0] seed, input bit rs);
    logic [DATA_W-1:0] w;
    logic [7:0]        b;
    w = '0;
    b = seed;
    for (int k = 0; k < NB; k++) begin
      if (rs && k < OH_BYTES) begin
        w[DATA_W-1-8*k -: 8] = 8'hA5;
      end else begin
        b = b + 8'd1;
        w[DATA_W-1-8*k -: 8] = b;
      end
    end
    return w;
  endfunction

  function automatic logic [N_CH-1:0] lock_vec();
    logic [N_CH-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c] = (m_st[c] == L);
    return v;
  endfunction

  // One clock: drive inputs, advance the model, then compare outputs.
  task automatic cyc(input bit v, input int ch, input logic [DATA_W-1:0] d, input bit fs,
                     input bit rs, input logic [7:0] m, input bit rq, input int rch,
                     input bit clr, input bit chk);
    bit bad, fev;
    int pre, e_fr, e_fe, e_we;
    i_valid = v; i_chid = CH_W'(ch); i_data = d; i_fs = fs; i_rs = rs; i_mfas = m;
    i_rd_req = rq; i_rd_chid = CH_W'(rch); i_rd_clr = clr;
    e_fr = m_fr[rch]; e_fe = m_fe[rch]; e_we = WERR_EN ? m_we[rch] : 0;
    bad = 1'b0; fev = 1'b0; pre = m_st[ch];
    if (v) begin
      fev = fs && rs;
      if (pre == H) begin
        if (fev) begin m_st[ch] = S; m_cnt[ch] = 0; end
      end else begin
        bad = !m_good(ch, d, fs, rs, m);
        if (pre == S) begin
          if (bad) begin
            m_st[ch] = H; m_cnt[ch] = 0;
          end else begin
            m_cnt[ch]++;
            if (m_cnt[ch] == LOCK_N) begin m_st[ch] = L; m_cnt[ch] = 0; end
          end
        end else if (!bad) begin
          m_cnt[ch] = 0;
        end else begin
          m_cnt[ch]++;
          if (m_cnt[ch] == LOSS_N) begin m_st[ch] = H; m_cnt[ch] = 0; end
        end
      end
      m_lb[ch] = d[7:0];
      m_lm[ch] = m;
    end
    if (rq && clr) begin m_fr[rch] = 0; m_fe[rch] = 0; m_we[rch] = 0; end
    if (fev) begin
      m_fr[ch] = sat1(m_fr[ch]);
      if (pre != L) m_fe[ch] = sat1(m_fe[ch]);
    end
    if (bad) m_we[ch] = sat1(m_we[ch]);
    @(posedge clk);
    #1;
    if (chk) begin
      do_check("err_pulse", 64'(o_err_pulse), 64'(bad));
      if (bad) do_check("err_chid", 64'(o_err_chid), 64'(ch));
      do_check("lock", 64'(o_lock), 64'(lock_vec()));
      do_check("rd_valid", 64'(o_rd_valid), 64'(rq));
      if (rq) begin
        do_check("rd_frames", 64'(o_rd_frames), 64'(e_fr));
        do_check("rd_ferr", 64'(o_rd_ferr), 64'(e_fe));
        do_check("rd_werr", 64'(o_rd_werr), 64'(e_we));
      end
    end
    i_valid = 1'b0; i_rd_req = 1'b0; i_rd_clr = 1'b0; i_fs = 1'b0; i_rs = 1'b0;
  endtask

  task automatic send(input int ch, input bit fs, input bit rs, input logic [7:0] m, input bit corrupt);
    logic [DATA_W-1:0] d;
    d = mkword(m_lb[ch], rs);
    if (corrupt) d[DATA_W-1-8*10 -: 8] = d[DATA_W-1-8*10 -: 8] ^ 8'hFF;
    cyc(1'b1, ch, d, fs, rs, m, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic rd(input int ch, input bit clr);
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 8'd0, 1'b1, ch, clr, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_chid = '0; i_data = '0; i_fs = 1'b0; i_rs = 1'b0;
    i_mfas = 8'd0; i_rd_req = 1'b0; i_rd_chid = '0; i_rd_clr = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    do_check("rst_lock", 64'(o_lock), 64'd0);
    do_check("rst_err", 64'(o_err_pulse), 64'd0);
    do_check("rst_rd_valid", 64'(o_rd_valid), 64'd0);
    do_check("rst_rd_frames", 64'(o_rd_frames), 64'd0);
    rst = 1'b0;

    // Test 1/2: ch3 lock after 4 good words, survives 2 bad, lost after 3 bad
    tbl[0]  = '{3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{3, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0};
    tbl[5]  = '{3, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1};
    tbl[6]  = '{3, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1};
    tbl[7]  = '{3, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0};
    tbl[8]  = '{3, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1};
    tbl[9]  = '{3, 1'b0, 1'b0, 1'b1, 8'h08, 1'b1};
    tbl[10] = '{3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].ch, tbl[i].fs, tbl[i].rs, 8'h00, tbl[i].bad);
      do_check("tbl_lock", 64'(o_lock), 64'(tbl[i].exp_lock));
      do_check("tbl_err", 64'(o_err_pulse), 64'(tbl[i].exp_err));
      if (tbl[i].exp_err) do_check("tbl_err_chid", 64'(o_err_chid), 64'd3);
    end

    // Test 3: locked ch0, frame start without MFAS step is a bad word
    send(0, 1'b1, 1'b1, 8'h05, 1'b0);
    for (int i = 0; i < LOCK_N; i++) send(0, 1'b0, 1'b0, 8'h05, 1'b0);
    do_check("t3_locked", 64'(o_lock[0]), 64'd1);
    send(0, 1'b1, 1'b0, 8'h05, 1'b0);
    do_check("t3_err", 64'(o_err_pulse), 64'd1);
    do_check("t3_err_chid", 64'(o_err_chid), 64'd0);
    rd(0, 1'b0);
    do_check("t3_werr", 64'(o_rd_werr), WERR_EN ? 64'd1 : 64'd0);

    // Test 4: ch1 and ch2 interleaved every cycle
    cyc(1'b1, 1, mkword(8'($urandom()), 1'b1), 1'b1, 1'b1, 8'h10, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b1, 2, mkword(8'($urandom()), 1'b1), 1'b1, 1'b1, 8'h20, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < LOCK_N; i++) begin
      send(1, 1'b0, 1'b0, 8'h10, 1'b0);
      do_check("t4_no_err1", 64'(o_err_pulse), 64'd0);
      send(2, 1'b0, 1'b0, 8'h20, 1'b0);
      do_check("t4_no_err2", 64'(o_err_pulse), 64'd0);
    end
    do_check("t4_lock12", 64'(o_lock[2:1]), 64'd3);

    // Test 5: ch5 frame counter saturation and clear racing an increment
    for (int i = 0; i < CNT_MAX; i++)
      cyc(1'b1, 5, {12{$urandom()}}, 1'b1, 1'b1, 8'($urandom()), 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 5, {12{$urandom()}}, 1'b1, 1'b1, 8'($urandom()), 1'b0, 0, 1'b0, 1'b1);
    rd(5, 1'b0);
    do_check("t5_sat", 64'(o_rd_frames), 64'hFFFF);
    cyc(1'b1, 5, {12{$urandom()}}, 1'b1, 1'b1, 8'($urandom()), 1'b1, 5, 1'b1, 1'b1);
    do_check("t5_clr_old", 64'(o_rd_frames), 64'hFFFF);
    rd(5, 1'b0);
    do_check("t5_after_clr", 64'(o_rd_frames), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_ch  = $urandom_range(0, N_CH - 1);
      r_v   = ($urandom_range(0, 9) != 0);
      r_fs  = ($urandom_range(0, 7) == 0);
      r_rs  = r_fs ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      r_m   = r_fs ? m_lm[r_ch] + 8'd1 : m_lm[r_ch];
      if ($urandom_range(0, 19) == 0) r_m = r_m ^ 8'h01;
      r_d   = mkword(m_lb[r_ch], r_rs);
      if ($urandom_range(0, 15) == 0) r_d[DATA_W-1-8*20 -: 8] = r_d[DATA_W-1-8*20 -: 8] ^ 8'h3C;
      r_rq  = ($urandom_range(0, 3) == 0);
      r_rch = $urandom_range(0, N_CH - 1);
      r_clr = ($urandom_range(0, 1) == 1);
      cyc(r_v, r_ch, r_d, r_fs, r_rs, r_m, r_rq, r_rch, r_clr, 1'b1);
    end

    // Test 6: reset mid-frame while locked
    send(7, 1'b1, 1'b1, 8'h33, 1'b0);
    for (int i = 0; i < LOCK_N; i++) send(7, 1'b0, 1'b0, 8'h33, 1'b0);
    do_check("t6_locked", 64'(o_lock[7]), 64'd1);
    i_valid = 1'b1; i_chid = 3'd7; i_data = mkword(m_lb[7], 1'b0); i_mfas = 8'h33;
    rst = 1'b1;
    #1;
    do_check("t6_async_lock", 64'(o_lock), 64'd0);
    do_check("t6_async_err", 64'(o_err_pulse), 64'd0);
    i_valid = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      rd(c, 1'b0);
      do_check("t6_frames_zero", 64'(o_rd_frames), 64'd0);
    end
    send(3, 1'b0, 1'b0, 8'h77, 1'b1);
    do_check("t6_hunt_no_err", 64'(o_err_pulse), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
